serial_addsub: RTL



---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_if.sv | 44 ++++
 rtl/full_adder_1bit.sv | 13 +
 rtl/serial_addsub.sv | 107 ++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: sequencing states and
// their encoding width.
package serial_addsub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub. The producer and consumer
// sit on the master side; the arithmetic block is the slave.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid,
    output a,
    output b,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  cout,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output cout,
    output ovf
  );

endinterface

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell; purely combinational.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock,
// through a single full_adder_1bit cell with the carry held in a flop.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | in_ready high; operands loaded on in_valid
// ST_SHIFT | one result bit per cycle, WIDTH cycles
// ST_DONE  | out_valid high, outputs frozen until out_ready
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sub_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             accept;
  logic             last_bit;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;

  assign accept   = (state_q == ST_IDLE) && bus.in_valid;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  // Subtraction is a + ~b + 1: b is inverted bit by bit and the +1 enters
  // through the carry flop, which is preset to sub on accept.
  assign fa_b = b_sr[0] ^ sub_q;

  full_adder_1bit u_fa (
    .a    (a_sr[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.in_valid)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit)      state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == ST_DONE);
      if (accept) begin
        a_sr    <= bus.a;
        b_sr    <= bus.b;
        sub_q   <= bus.sub;
        carry_q <= bus.sub;
        cnt_q   <= '0;
      end else if (state_q == ST_SHIFT) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        res_q   <= {fa_sum, res_q[WIDTH-1:1]};
        carry_q <= fa_cout;
        cnt_q   <= cnt_q + 1'b1;
        // carry_q here is still the carry into the MSB
        if (last_bit) begin
          cout_q <= fa_cout;
          ovf_q  <= carry_q ^ fa_cout;
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule
